qupls4_stomp_event_counters: RTL and testbench
==============================================

# qupls4_stomp_event_counters

Parametrised performance-counter bank for the Qupls4 commit stage. Each cycle it counts squashed ROB entries from the stomp vector, committed instructions, and committed instructions that were stomped. It keeps the three totals in WID-bit counters and supports an edge-detect mode, so a stomp held for several cycles is counted once. Counters are read through a snapshot request/acknowledge port; the block also provides sticky overflow flags and a threshold interrupt.

## Interface
- WID, 40, counter width in bits (≥ 8)
- ROB_ENTRIES, 32, width of stomp vector
- CMT_WIDTH, 4, maximum commits per cycle
- SATURATE, 0, 1 = counters saturate at all-ones; 0 = counters wrap
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ce  in  1  commit-side clock enable; gates commit counting only
- cmtcnt  in  $clog2(CMT_WIDTH+1)  number of instructions committing this cycle
- cmt_stomped  in  CMT_WIDTH  stomped flag of each head slot; bit i is valid when i < cmtcnt
- stomp  in  ROB_ENTRIES  stomp vector for this cycle
- mode_edge  in  1  1 = count only the bits of stomp that newly rose; 0 = count every set bit every cycle
- freeze  in  1  suppress accumulation
- clr  in  1  synchronous clear of counters, flags, irq and pipeline
- thresh  in  WID  interrupt threshold; 0 disables the interrupt
- rd_req  in  1  read request, one-cycle pulse
- rd_sel  in  2  0 = stomp total, 1 = commit total, 2 = stomped-commit total, 3 = status
- rd_ack  out  1  read data valid, one-cycle pulse
- rd_data  out  WID  snapshot value
- ovf  out  3  sticky overflow flag per counter (bit = rd_sel index)
- irq  out  1  threshold interrupt, level

## Operation
- Stage 1 (registered):
  - inc_s = popcount(mode_edge ? stomp & ~stomp_q : stomp).
  - inc_c = ce ? min(cmtcnt, CMT_WIDTH) : 0.
  - inc_cs = ce ? popcount(cmt_stomped masked to slots < clamped cmtcnt) : 0.
- stomp_q samples stomp every cycle, regardless of freeze, ce or clr.
- Stage 2: when freeze=0, each counter adds its stage-1 increment.
  - If freeze=1, the stage-2 increment is discarded (not deferred).
- Width rules: increments are zero-extended to WID. An add with a carry out sets the matching ovf bit.
  - SATURATE=0: the result is the wrapped sum.
  - SATURATE=1: the counter holds at all-ones.
- Sticky flags: ovf bits stay set until clr or reset.
- irq: registered. It sets when thresh≠0 and the stomp-total counter's next value is ≥ thresh. It stays set until clr.
- clr has priority over accumulation. It zeroes the counters, ovf, irq and the stage-1 increments. stomp_q is not affected.
- Read port:
  - On rd_req, the current register value selected by rd_sel is latched. Any same-cycle increment is excluded.
  - rd_sel=3 returns {ovf, irq} in the low 4 bits, zero above.
  - rd_ack pulses the next cycle. rd_data holds until the next ack.
  - Back-to-back rd_req is accepted every cycle. A rd_req in the same cycle as clr returns the pre-clear value.

## Timing
- Reset (rst=0, asynchronous): counters, ovf, irq, rd_ack, rd_data, stage-1 registers and stomp_q are all zero.
- Latency: an input in cycle N is visible in a counter register after edge N+2. A read requested in cycle N+2 sees it.
- rd_req → rd_ack latency is exactly 1 cycle.
- irq asserts in the same cycle the counter reaches thresh.
- clr in cycle N: all counters read 0 after edge N+1. The input cycles N-1 and N contribute nothing.
- Edge mode:
  - The first cycle after reset, or after a mode_edge change, compares against stomp_q. stomp_q is 0 after reset.
  - A bit held high for k cycles counts once. A bit that drops and rises again counts twice.
- cmtcnt > CMT_WIDTH is clamped to CMT_WIDTH.
- Simultaneous freeze and clr: clr wins.

## Test plan
- Level count: ROB_ENTRIES=32, mode_edge=0, stomp=0x0000_00FF held 3 cycles, then 0 → stomp total = 24; rd_sel=0 returns 24 with rd_ack one cycle after rd_req.
- Edge count: mode_edge=1, same stimulus → total 8. Then stomp=0x0000_0001 for 1 cycle, 0 for 1 cycle, 0x0000_0001 for 1 cycle → total 10.
- Commits: cmtcnt=3, cmt_stomped=4'b1010, ce=1 for 5 cycles → commit total 15, stomped-commit total 5 (slot 3 masked). With ce=0 in one of those cycles → 12 and 4.
- Overflow: WID=8, stomp total preloaded to 250 via stomp=0xFF level for 31 cycles plus 2 bits, then +8.
  - SATURATE=0: count 2, ovf[0]=1.
  - SATURATE=1: count 255, ovf[0]=1.
  - rd_sel=3 returns 4'b0010.
- Threshold and clr: thresh=16, stomp=0xFFFF for 1 cycle → irq=1 two cycles later. clr pulse → all counters 0, irq=0, ovf=0 after the next edge.
- Async reset mid-operation: rst low between edges while counters are nonzero → all outputs 0 immediately. Counting resumes from 0 two cycles after rst rises.

Source files
------------

// File: rtl/qupls4_stomp_event_counters.sv
// Commit-stage performance counters: stomped ROB entries, commits and stomped commits.
// Two-stage pipeline (popcount, then accumulate) with a snapshot read port, sticky overflow and threshold irq.
module qupls4_stomp_event_counters #(
  parameter int unsigned WID         = 40,
  parameter int unsigned ROB_ENTRIES = 32,
  parameter int unsigned CMT_WIDTH   = 4,
  parameter int unsigned SATURATE    = 0,
  localparam int unsigned CW         = $clog2(CMT_WIDTH + 1),
  localparam int unsigned SW         = $clog2(ROB_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [CW-1:0]          cmtcnt,
  input  logic [CMT_WIDTH-1:0]   cmt_stomped,
  input  logic [ROB_ENTRIES-1:0] stomp,
  input  logic                   mode_edge,
  input  logic                   freeze,
  input  logic                   clr,
  input  logic [WID-1:0]         thresh,
  input  logic                   rd_req,
  input  logic [1:0]             rd_sel,
  output logic                   rd_ack,
  output logic [WID-1:0]         rd_data,
  output logic [2:0]             ovf,
  output logic                   irq
);

  logic [ROB_ENTRIES-1:0] stomp_q;
  logic [ROB_ENTRIES-1:0] stomp_sel;
  logic [CW-1:0]          cmt_clamped;
  logic [CMT_WIDTH-1:0]   slot_mask;
  logic [SW-1:0]          inc_s_d, inc_s_q;
  logic [CW-1:0]          inc_c_d, inc_c_q;
  logic [CW-1:0]          inc_cs_d, inc_cs_q;

  logic [WID-1:0] inc_ext [3];
  logic [WID:0]   sum     [3];
  logic [WID-1:0] cnt_q   [3];
  logic [WID-1:0] cnt_d   [3];
  logic [2:0]     ovf_q, ovf_d;
  logic           irq_q, irq_d;
  logic           rd_ack_q;
  logic [WID-1:0] rd_data_q, rd_mux;

  // ---------------- stage 1: per-cycle increments ----------------
  assign stomp_sel   = mode_edge ? (stomp & ~stomp_q) : stomp;
  assign cmt_clamped = (cmtcnt > CW'(CMT_WIDTH)) ? CW'(CMT_WIDTH) : cmtcnt;

  // Only head slots below the (clamped) commit count carry a meaningful stomped flag.
  for (genvar gi = 0; gi < int'(CMT_WIDTH); gi++) begin : g_slot
    assign slot_mask[gi] = (CW'(gi) < cmt_clamped) && cmt_stomped[gi];
  end

  always_comb begin
    inc_s_d  = '0;
    inc_cs_d = '0;
    for (int i = 0; i < int'(ROB_ENTRIES); i++)
      inc_s_d = inc_s_d + SW'(stomp_sel[i]);
    for (int i = 0; i < int'(CMT_WIDTH); i++)
      inc_cs_d = inc_cs_d + CW'(slot_mask[i]);
    if (!ce) inc_cs_d = '0;
    inc_c_d = ce ? cmt_clamped : '0;
  end

  // ---------------- stage 2: accumulate ----------------
  assign inc_ext[0] = WID'(inc_s_q);
  assign inc_ext[1] = WID'(inc_c_q);
  assign inc_ext[2] = WID'(inc_cs_q);

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    assign sum[gi] = {1'b0, cnt_q[gi]} + {1'b0, inc_ext[gi]};
    always_comb begin
      cnt_d[gi] = cnt_q[gi];
      ovf_d[gi] = ovf_q[gi];
      if (!freeze) begin
        ovf_d[gi] = ovf_q[gi] | sum[gi][WID];
        if (sum[gi][WID] && (SATURATE != 0))
          cnt_d[gi] = '1;
        else
          cnt_d[gi] = sum[gi][WID-1:0];
      end
    end
  end

  // Threshold looks at the stomp counter's next value so irq rises with the counter.
  assign irq_d = irq_q | ((thresh != '0) && (cnt_d[0] >= thresh));

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      2'd0:    rd_mux = cnt_q[0];
      2'd1:    rd_mux = cnt_q[1];
      2'd2:    rd_mux = cnt_q[2];
      default: rd_mux = WID'({ovf_q, irq_q});
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stomp_q   <= '0;
      inc_s_q   <= '0;
      inc_c_q   <= '0;
      inc_cs_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      ovf_q     <= '0;
      irq_q     <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      stomp_q  <= stomp;
      rd_ack_q <= rd_req;
      if (rd_req) rd_data_q <= rd_mux;
      if (clr) begin
        inc_s_q  <= '0;
        inc_c_q  <= '0;
        inc_cs_q <= '0;
        for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        ovf_q    <= '0;
        irq_q    <= 1'b0;
      end else begin
        inc_s_q  <= inc_s_d;
        inc_c_q  <= inc_c_d;
        inc_cs_q <= inc_cs_d;
        for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        ovf_q    <= ovf_d;
        irq_q    <= irq_d;
      end
    end
  end

  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_qupls4_stomp_event_counters.sv
// Directed bench: a wrapping and a saturating 8-bit instance share stimulus; reads are scored by a monitor.
module tb_qupls4_stomp_event_counters;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [2:0]  cmtcnt = '0;
  logic [3:0]  cmt_stomped = '0;
  logic [31:0] stomp = '0;
  logic        mode_edge = 1'b0;
  logic        freeze = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  thresh = '0;
  logic        rd_req = 1'b0;
  logic [1:0]  rd_sel = '0;

  logic        rd_ack0, rd_ack1, irq0, irq1;
  logic [7:0]  rd_data0, rd_data1;
  logic [2:0]  ovf0, ovf1;

  int total = 0;
  int bad   = 0;
  int tag   = 0;

  typedef struct {
    int         id;
    logic [1:0] sel;
    logic [7:0] e0;
    logic [7:0] e1;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  qupls4_stomp_event_counters #(.WID(8), .ROB_ENTRIES(32), .CMT_WIDTH(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .ce(ce), .cmtcnt(cmtcnt), .cmt_stomped(cmt_stomped), .stomp(stomp),
    .mode_edge(mode_edge), .freeze(freeze), .clr(clr), .thresh(thresh), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_ack(rd_ack0), .rd_data(rd_data0), .ovf(ovf0), .irq(irq0));

  qupls4_stomp_event_counters #(.WID(8), .ROB_ENTRIES(32), .CMT_WIDTH(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .ce(ce), .cmtcnt(cmtcnt), .cmt_stomped(cmt_stomped), .stomp(stomp),
    .mode_edge(mode_edge), .freeze(freeze), .clr(clr), .thresh(thresh), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_ack(rd_ack1), .rd_data(rd_data1), .ovf(ovf1), .irq(irq1));

  function automatic void check(string nm, int unsigned act, int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endfunction

  // Monitor: every ack pops one expected read and checks both instances.
  always @(negedge clk) begin
    if (rst && (rd_ack0 || rd_ack1)) begin
      if (sb.size() == 0) begin
        check("spurious_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("rd%0d_sel%0d_ack_sat", e.id, e.sel), 32'(rd_ack1), 1);
        check($sformatf("rd%0d_sel%0d_wrap", e.id, e.sel), 32'(rd_data0), 32'(e.e0));
        check($sformatf("rd%0d_sel%0d_sat", e.id, e.sel), 32'(rd_data1), 32'(e.e1));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic req(input logic [1:0] sel, input logic [7:0] e0, input logic [7:0] e1);
    exp_t e;
    e.id = tag; e.sel = sel; e.e0 = e0; e.e1 = e1;
    tag++;
    sb.push_back(e);
    rd_req = 1'b1;
    rd_sel = sel;
    step();
    rd_req = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    check("reset_wrap", 32'({rd_ack0, irq0, ovf0, rd_data0}), 0);
    check("reset_sat", 32'({rd_ack1, irq1, ovf1, rd_data1}), 0);
    #10 rst = 1'b1;
    step();

    // level mode: 0xFF for 3 cycles -> 24
    stomp = 32'h0000_00FF; idle(3);
    stomp = '0; idle(2);
    req(2'd0, 8'd24, 8'd24);

    // edge mode: held 0xFF counts once, then two separate rises of bit 0
    do_clr();
    mode_edge = 1'b1;
    stomp = 32'h0000_00FF; idle(3);
    stomp = '0; idle(2);
    req(2'd0, 8'd8, 8'd8);
    stomp = 32'h1; idle(1);
    stomp = '0;    idle(1);
    stomp = 32'h1; idle(1);
    stomp = '0;    idle(2);
    req(2'd0, 8'd10, 8'd10);
    mode_edge = 1'b0;

    // commits: 3 per cycle, slots 0..2 of 1010 -> one stomped per cycle
    do_clr();
    ce = 1'b1; cmtcnt = 3'd3; cmt_stomped = 4'b1010; idle(5);
    ce = 1'b0; idle(2);
    req(2'd1, 8'd15, 8'd15);
    req(2'd2, 8'd5, 8'd5);

    // same with ce low in one of the five cycles
    do_clr();
    ce = 1'b1; idle(2);
    ce = 1'b0; idle(1);
    ce = 1'b1; idle(2);
    ce = 1'b0; cmtcnt = '0; cmt_stomped = '0; idle(2);
    req(2'd1, 8'd12, 8'd12);
    req(2'd2, 8'd4, 8'd4);

    // cmtcnt above CMT_WIDTH clamps to 4
    do_clr();
    ce = 1'b1; cmtcnt = 3'd7; cmt_stomped = 4'b1111; idle(1);
    ce = 1'b0; cmtcnt = '0; cmt_stomped = '0; idle(2);
    req(2'd1, 8'd4, 8'd4);
    req(2'd2, 8'd4, 8'd4);

    // freeze discards the increment rather than deferring it
    do_clr();
    freeze = 1'b1;
    stomp = 32'h0000_00FF; idle(1);
    stomp = '0; idle(1);
    freeze = 1'b0; idle(2);
    req(2'd0, 8'd0, 8'd0);

    // overflow: 31*8 + 2 = 250, then +8 wraps to 2 or saturates at 255
    do_clr();
    stomp = 32'h0000_00FF; idle(31);
    stomp = 32'h3; idle(1);
    stomp = '0; idle(2);
    req(2'd0, 8'd250, 8'd250);
    check("ovf_before_wrap", 32'(ovf0), 0);
    stomp = 32'h0000_00FF; idle(1);
    stomp = '0; idle(2);
    req(2'd0, 8'd2, 8'd255);
    req(2'd3, 8'h02, 8'h02);
    check("ovf_wrap", 32'(ovf0), 1);
    check("ovf_sat", 32'(ovf1), 1);

    // threshold interrupt and clear
    do_clr();
    check("ovf_after_clr", 32'({ovf0, ovf1}), 0);
    thresh = 8'd16;
    stomp = 32'h0000_FFFF; step();
    stomp = '0;
    check("irq_one_edge", 32'({irq0, irq1}), 0);
    step();
    check("irq_two_edges", 32'({irq0, irq1}), 3);
    req(2'd3, 8'h01, 8'h01);
    clr = 1'b1;
    req(2'd0, 8'd16, 8'd16);   // same-cycle clr: pre-clear value
    clr = 1'b0;
    check("irq_after_clr", 32'({irq0, irq1}), 0);
    check("ovf_after_clr2", 32'({ovf0, ovf1}), 0);
    req(2'd0, 8'd0, 8'd0);

    // asynchronous reset mid-operation
    stomp = 32'h0000_00FF; idle(3);
    stomp = '0; idle(2);
    req(2'd0, 8'd24, 8'd24);
    @(negedge clk);
    #2;
    check("irq_before_rst", 32'(irq0), 1);
    rst = 1'b0;
    #1;
    check("async_rst_wrap", 32'({rd_ack0, irq0, ovf0, rd_data0}), 0);
    check("async_rst_sat", 32'({rd_ack1, irq1, ovf1, rd_data1}), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    stomp = 32'h0000_000F;
    step();
    stomp = '0; idle(2);
    req(2'd0, 8'd4, 8'd4);
    req(2'd1, 8'd0, 8'd0);
    check("irq_after_rst", 32'(irq0), 0);

    idle(3);
    if (sb.size() != 0) check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
